ysyx_22041071_axi_rd_arbiter: RTL and testbench

Shares the core's single AXI4 read channel between the instruction-fetch requester (IF, from the PC stage) and the load requester (LS, from the memory stage). Requests are granted round-robin. Exactly one transaction is outstanding at a time. The block drives AR, collects the R burst and routes the beats back to the granted requester. It sits between the core's fetch/load ports and the AXI crossbar or SoC bus.

---
 rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv | 23 ++
 rtl/ysyx_22041071_rr_arb2.sv | 38 +++
 rtl/ysyx_22041071_axi_rd_arbiter.sv | 142 ++++++++++++++
 tb/tb_ysyx_22041071_axi_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter.
//   - FSM state encoding (IDLE / ADDR / DATA)
//   - requester indices, which double as the AXI ID of each requester
//   - AXI burst type and default bus widths
package ysyx_22041071_axi_rd_arbiter_pkg;

    localparam int unsigned ysyx_22041071_ADDR_BUS       = 64;
    localparam int unsigned ysyx_22041071_DATA_BUS       = 64;
    localparam int unsigned ysyx_22041071_AXI_LEN_WIDTH  = 8;
    localparam int unsigned ysyx_22041071_AXI_ID_WIDTH   = 4;

    localparam int unsigned REQ_IF = 0;
    localparam int unsigned REQ_LS = 1;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ysyx_22041071_ARB_IDLE = 2'd0,
        ysyx_22041071_ARB_ADDR = 2'd1,
        ysyx_22041071_ARB_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_22041071_rr_arb2.sv
// Two-way round-robin grant.
//   clk, reset   : clock, synchronous active-high reset
//   req_i[1:0]   : request vector, bit index = requester index
//   accept_i     : the current grant is being taken this cycle
//   gnt_o[1:0]   : one-hot grant (combinational)
// The last-grant pointer resets to LS so IF wins the first tie, and only
// moves when a grant is actually accepted.
module ysyx_22041071_rr_arb2
    import ysyx_22041071_axi_rd_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (accept_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[REQ_LS];
        end
    end

endmodule

// File: rtl/ysyx_22041071_axi_rd_arbiter.sv
// Shares one AXI4 read channel between instruction fetch (IF) and load (LS).
// One transaction outstanding; round-robin grant; R beats routed to owner.
//   clk, reset                : clock, synchronous active-high reset
//   if_/ls_ar_valid,addr,len,size : requester AR side; *_ar_ready out
//   if_/ls_r_valid, r_data/resp/last : beats back to the owning requester
//   axi_ar_*, axi_r_*         : AXI4 master read channel
//   proto_err                 : sticky burst-length / ID mismatch flag
//
// state | meaning
// IDLE  | choose a requester, latch its request on the grant edge
// ADDR  | present latched AR until axi_ar_ready
// DATA  | accept R beats until a beat with axi_r_last
module ysyx_22041071_axi_rd_arbiter
    import ysyx_22041071_axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ysyx_22041071_ADDR_BUS,
    parameter int unsigned DATA_W = ysyx_22041071_DATA_BUS,
    parameter int unsigned LEN_W  = ysyx_22041071_AXI_LEN_WIDTH,
    parameter int unsigned ID_W   = ysyx_22041071_AXI_ID_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_ar_valid,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [LEN_W-1:0]  if_len,
    input  logic [1:0]        if_size,
    output logic              if_ar_ready,
    input  logic              ls_ar_valid,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [LEN_W-1:0]  ls_len,
    input  logic [1:0]        ls_size,
    output logic              ls_ar_ready,
    output logic              if_r_valid,
    output logic              ls_r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,
    output logic [ADDR_W-1:0] axi_ar_addr,
    output logic [LEN_W-1:0]  axi_ar_len,
    output logic [2:0]        axi_ar_size,
    output logic [1:0]        axi_ar_burst,
    output logic [ID_W-1:0]   axi_ar_id,
    input  logic              axi_r_valid,
    output logic              axi_r_ready,
    input  logic [DATA_W-1:0] axi_r_data,
    input  logic [1:0]        axi_r_resp,
    input  logic              axi_r_last,
    input  logic [ID_W-1:0]   axi_r_id,
    output logic              proto_err
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        size_q;
    logic [ID_W-1:0]   id_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              proto_err_q;

    logic [1:0] gnt;
    logic       grant_fire;
    logic       beat_fire;
    logic       owner_ls;
    logic       beat_err;

    // Requests are only taken in IDLE; reset masks the combinational ready
    // so nothing looks accepted while the block is being reset.
    assign grant_fire = (state_q == ysyx_22041071_ARB_IDLE) && (gnt != 2'b00) && !reset;

    ysyx_22041071_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({ls_ar_valid, if_ar_valid}),
        .accept_i (grant_fire),
        .gnt_o    (gnt)
    );

    assign if_ar_ready = grant_fire && gnt[REQ_IF];
    assign ls_ar_ready = grant_fire && gnt[REQ_LS];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ysyx_22041071_ARB_IDLE: if (grant_fire)               state_d = ysyx_22041071_ARB_ADDR;
            ysyx_22041071_ARB_ADDR: if (axi_ar_ready)             state_d = ysyx_22041071_ARB_DATA;
            ysyx_22041071_ARB_DATA: if (beat_fire && axi_r_last)  state_d = ysyx_22041071_ARB_IDLE;
            default:                                              state_d = ysyx_22041071_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ysyx_22041071_ARB_IDLE;
        else       state_q <= state_d;
    end

    assign axi_ar_valid = (state_q == ysyx_22041071_ARB_ADDR);
    assign axi_r_ready  = (state_q == ysyx_22041071_ARB_DATA);
    assign beat_fire    = axi_r_ready && axi_r_valid;
    assign owner_ls     = (id_q == ID_W'(REQ_LS));

    // Error if last arrives early/late relative to the latched length, or the
    // slave answers with a foreign ID. The burst still ends only on r_last.
    assign beat_err = (axi_r_last != (cnt_q == len_q)) || (axi_r_id != id_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (grant_fire) begin
                addr_q <= gnt[REQ_LS] ? ls_addr : if_addr;
                len_q  <= gnt[REQ_LS] ? ls_len  : if_len;
                size_q <= gnt[REQ_LS] ? ls_size : if_size;
                id_q   <= gnt[REQ_LS] ? ID_W'(REQ_LS) : ID_W'(REQ_IF);
                cnt_q  <= '0;
            end else if (beat_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (beat_fire && beat_err) proto_err_q <= 1'b1;
        end
    end

    assign axi_ar_addr  = addr_q;
    assign axi_ar_len   = len_q;
    assign axi_ar_size  = {1'b0, size_q};
    assign axi_ar_burst = BURST_INCR;
    assign axi_ar_id    = id_q;

    assign if_r_valid = beat_fire && !owner_ls;
    assign ls_r_valid = beat_fire && owner_ls;
    assign r_data     = axi_r_data;
    assign r_resp     = axi_r_resp;
    assign r_last     = axi_r_last;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arbiter.sv
module tb_ysyx_22041071_axi_rd_arbiter;

    logic        clk, reset;
    logic        if_ar_valid, ls_ar_valid;
    logic [63:0] if_addr, ls_addr;
    logic [7:0]  if_len, ls_len;
    logic [1:0]  if_size, ls_size;
    logic        if_ar_ready, ls_ar_ready;
    logic        if_r_valid, ls_r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        axi_ar_valid, axi_ar_ready;
    logic [63:0] axi_ar_addr;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size;
    logic [1:0]  axi_ar_burst;
    logic [3:0]  axi_ar_id;
    logic        axi_r_valid, axi_r_ready;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic        axi_r_last;
    logic [3:0]  axi_r_id;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    ysyx_22041071_axi_rd_arbiter dut (
        .clk(clk), .reset(reset),
        .if_ar_valid(if_ar_valid), .if_addr(if_addr), .if_len(if_len), .if_size(if_size),
        .if_ar_ready(if_ar_ready),
        .ls_ar_valid(ls_ar_valid), .ls_addr(ls_addr), .ls_len(ls_len), .ls_size(ls_size),
        .ls_ar_ready(ls_ar_ready),
        .if_r_valid(if_r_valid), .ls_r_valid(ls_r_valid),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
        .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
        .axi_ar_burst(axi_ar_burst), .axi_ar_id(axi_ar_id),
        .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
        .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
        .axi_r_id(axi_r_id), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int obs_beats;
        logic [7:0] pat;
        logic [3:0] e;

        reset = 1'b1;
        if_ar_valid = 0; ls_ar_valid = 0;
        if_addr = 0; ls_addr = 0; if_len = 0; ls_len = 0; if_size = 0; ls_size = 0;
        axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0;
        axi_r_last = 0; axi_r_id = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_ar_valid", 64'(axi_ar_valid), 64'd0);
        chk("rst_r_ready",  64'(axi_r_ready),  64'd0);
        chk("rst_if_ready", 64'(if_ar_ready),  64'd0);
        chk("rst_proto",    64'(proto_err),    64'd0);
        chk("rst_addr",     axi_ar_addr,       64'd0);
        chk("rst_id",       64'(axi_ar_id),    64'd0);

        // Lone IF read, len=0, slave ready at once
        if_ar_valid = 1; if_addr = 64'h8000_0000; if_len = 0; if_size = 2'd3;
        #1;
        chk("t1_if_ready", 64'(if_ar_ready), 64'd1);
        chk("t1_ls_ready", 64'(ls_ar_ready), 64'd0);
        tick();
        if_ar_valid = 0; axi_ar_ready = 1;
        #1;
        chk("t1_ar_valid", 64'(axi_ar_valid), 64'd1);
        chk("t1_ar_addr",  axi_ar_addr, 64'h8000_0000);
        chk("t1_ar_id",    64'(axi_ar_id), 64'd0);
        chk("t1_ar_size",  64'(axi_ar_size), 64'd3);
        chk("t1_ar_burst", 64'(axi_ar_burst), 64'd1);
        chk("t1_ar_len",   64'(axi_ar_len), 64'd0);
        tick();
        axi_ar_ready = 0;
        axi_r_valid = 1; axi_r_last = 1; axi_r_id = 0; axi_r_data = 64'h1111; axi_r_resp = 2'd2;
        #1;
        chk("t1_r_ready",  64'(axi_r_ready), 64'd1);
        chk("t1_ar_drop",  64'(axi_ar_valid), 64'd0);
        chk("t1_if_rv",    64'(if_r_valid), 64'd1);
        chk("t1_ls_rv",    64'(ls_r_valid), 64'd0);
        chk("t1_rdata",    r_data, 64'h1111);
        chk("t1_rresp",    64'(r_resp), 64'd2);
        chk("t1_rlast",    64'(r_last), 64'd1);
        tick();
        axi_r_valid = 0; axi_r_last = 0; axi_r_resp = 0;
        #1;
        chk("t1_idle", 64'(axi_r_ready), 64'd0);
        chk("t1_proto", 64'(proto_err), 64'd0);

        // Tie after reset: IF first, then strict alternation with both held
        reset = 1; tick(); reset = 0;
        if_ar_valid = 1; ls_ar_valid = 1;
        if_addr = 64'h100; ls_addr = 64'h200; if_len = 0; ls_len = 0;
        for (int i = 0; i < 6; i++) begin
            e = 4'(i % 2);
            #1;
            chk("t2_if_ready", 64'(if_ar_ready), 64'(e == 0));
            chk("t2_ls_ready", 64'(ls_ar_ready), 64'(e == 1));
            tick();
            axi_ar_ready = 1;
            #1;
            chk("t2_ar_id", 64'(axi_ar_id), 64'(e));
            chk("t2_ar_addr", axi_ar_addr, (e == 0) ? 64'h100 : 64'h200);
            tick();
            axi_ar_ready = 0;
            axi_r_valid = 1; axi_r_last = 1; axi_r_id = e; axi_r_data = 64'(i);
            #1;
            chk("t2_if_rv", 64'(if_r_valid), 64'(e == 0));
            chk("t2_ls_rv", 64'(ls_r_valid), 64'(e == 1));
            tick();
            axi_r_valid = 0; axi_r_last = 0;
        end
        if_ar_valid = 0; ls_ar_valid = 0;
        #1;
        chk("t2_proto", 64'(proto_err), 64'd0);

        // LS burst len=3 with gaps
        ls_ar_valid = 1; ls_addr = 64'h1000; ls_len = 8'd3; ls_size = 2'd2;
        #1;
        chk("t3_ls_ready", 64'(ls_ar_ready), 64'd1);
        tick();
        ls_ar_valid = 0; axi_ar_ready = 1;
        #1;
        chk("t3_ar_len",  64'(axi_ar_len), 64'd3);
        chk("t3_ar_id",   64'(axi_ar_id), 64'd1);
        chk("t3_ar_size", 64'(axi_ar_size), 64'd2);
        tick();
        axi_ar_ready = 0;
        pat = 8'b1011_0010;
        obs_beats = 0;
        for (int i = 0; i < 8; i++) begin
            axi_r_valid = pat[i];
            axi_r_last  = pat[i] && (obs_beats == 3);
            axi_r_id    = 4'd1;
            axi_r_data  = 64'hA0 + 64'(obs_beats);
            #1;
            chk("t3_if_rv", 64'(if_r_valid), 64'd0);
            chk("t3_ls_rv", 64'(ls_r_valid), 64'(pat[i]));
            if (ls_r_valid) begin
                chk("t3_rdata", r_data, 64'hA0 + 64'(obs_beats));
                obs_beats++;
            end
            tick();
        end
        axi_r_valid = 0; axi_r_last = 0;
        #1;
        chk("t3_beats", 64'(obs_beats), 64'd4);
        chk("t3_idle",  64'(axi_r_ready), 64'd0);
        chk("t3_proto", 64'(proto_err), 64'd0);

        // AR stall 5 cycles with IF pending
        ls_ar_valid = 1; ls_addr = 64'h2000; ls_len = 8'd1;
        tick();
        ls_ar_valid = 0;
        if_ar_valid = 1; if_addr = 64'h3000; if_len = 8'd3; if_size = 2'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_ar_valid", 64'(axi_ar_valid), 64'd1);
            chk("t4_ar_addr",  axi_ar_addr, 64'h2000);
            chk("t4_ar_len",   64'(axi_ar_len), 64'd1);
            chk("t4_ar_id",    64'(axi_ar_id), 64'd1);
            chk("t4_if_ready", 64'(if_ar_ready), 64'd0);
            tick();
        end
        axi_ar_ready = 1;
        tick();
        axi_ar_ready = 0;
        axi_r_valid = 1; axi_r_id = 4'd1; axi_r_last = 0;
        #1;
        chk("t4_data_if_ready", 64'(if_ar_ready), 64'd0);
        tick();
        axi_r_last = 1;
        tick();
        axi_r_valid = 0; axi_r_last = 0;
        #1;
        chk("t4_proto", 64'(proto_err), 64'd0);
        chk("t4_if_granted", 64'(if_ar_ready), 64'd1);

        // Early r_last on beat 2 of len=3
        tick();
        if_ar_valid = 0; axi_ar_ready = 1;
        #1;
        chk("t5_ar_len", 64'(axi_ar_len), 64'd3);
        chk("t5_ar_addr", axi_ar_addr, 64'h3000);
        tick();
        axi_ar_ready = 0;
        axi_r_valid = 1; axi_r_id = 4'd0; axi_r_last = 0;
        tick();
        axi_r_last = 1;
        tick();
        axi_r_valid = 0; axi_r_last = 0;
        #1;
        chk("t5_proto", 64'(proto_err), 64'd1);
        chk("t5_idle",  64'(axi_r_ready), 64'd0);
        tick(); tick();
        chk("t5_sticky", 64'(proto_err), 64'd1);

        // Reset in DATA after one beat
        if_ar_valid = 1; if_addr = 64'h5000; if_len = 8'd1;
        tick();
        if_ar_valid = 0; axi_ar_ready = 1;
        tick();
        axi_ar_ready = 0;
        axi_r_valid = 1; axi_r_id = 4'd0; axi_r_last = 0;
        tick();
        axi_r_valid = 0;
        reset = 1;
        tick();
        #1;
        chk("t6_r_ready", 64'(axi_r_ready), 64'd0);
        chk("t6_ar_valid", 64'(axi_ar_valid), 64'd0);
        chk("t6_proto",   64'(proto_err), 64'd0);
        chk("t6_addr",    axi_ar_addr, 64'd0);
        reset = 0;
        if_ar_valid = 1; if_addr = 64'h4000; if_len = 0;
        #1;
        chk("t6_if_ready", 64'(if_ar_ready), 64'd1);
        tick();
        if_ar_valid = 0; axi_ar_ready = 1;
        #1;
        chk("t6_ar_addr", axi_ar_addr, 64'h4000);
        tick();
        axi_ar_ready = 0;
        axi_r_valid = 1; axi_r_last = 1; axi_r_id = 0; axi_r_data = 64'h4444;
        #1;
        chk("t6_if_rv", 64'(if_r_valid), 64'd1);
        chk("t6_rdata", r_data, 64'h4444);
        tick();
        axi_r_valid = 0; axi_r_last = 0;
        #1;
        chk("t6_idle",   64'(axi_r_ready), 64'd0);
        chk("t6_proto2", 64'(proto_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
